video_pll_sequencer: RTL and testbench
======================================

Name: video_pll_sequencer

Overview:
- Run-time mode-switching controller for the HDMI/VGA PLL path, running on the 25 MHz board clock.
- Selects one of NUM_MODES pixel-clock configurations and pulses the PLL reset.
- Qualifies the PLL lock with a filter and timeout, retries on failure, and holds the video pipeline in reset until the clocks are stable.
- Sits between the top-level mode register and the ecp5pll-based clock generator; also releases video_rst_n to the timing generator and TMDS encoder.

Parameters:
- NUM_MODES, 4, number of selectable pixel-clock configurations.
- MODE_W, $clog2(NUM_MODES), width of mode index.
- PLL_RST_CYCLES, 16, width of the PLL reset pulse in clk_25mhz cycles.
- LOCK_TIMEOUT, 250000, cycles allowed for first lock assertion (10 ms).
- STABLE_CYCLES, 2500, cycles lock must stay continuously high before run (100 us).
- MAX_RETRIES, 3, PLL reset attempts per request before fault.
- CNT_W, 8, width of the diagnostic counters.

Ports:
- clk_25mhz, in, 1, board reference clock; the only clock.
- rst_n, in, 1, asynchronous active-low reset.
- mode_sel, in, MODE_W, requested mode index; sampled only on mode_req.
- mode_req, in, 1, single-cycle request strobe.
- pll_locked_async, in, 1, raw PLL lock, asynchronous to clk_25mhz.
- pll_rst, out, 1, active-high PLL reset.
- pll_mode, out, MODE_W, registered mode index driving PLL configuration mux.
- video_rst_n, out, 1, active-low reset for pixel-domain logic.
- mode_ready, out, 1, high while in RUN.
- busy, out, 1, high in PLL_RST, WAIT_LOCK, STABLE.
- fault, out, 1, high in FAULT.
- retry_cnt, out, 2, attempts used in the current sequence.
- lock_loss_cnt, out, CNT_W, saturating count of lock drops while in RUN.

Behaviour:
- Reset values:
  - pll_rst=1, video_rst_n=0, pll_mode=0, mode_ready=0, busy=1, fault=0.
  - Both counters 0; sync flops 0; state PLL_RST with the pulse counter cleared.
  - After reset, the block sequences mode 0 automatically.
- Sync: pll_locked_async passes through a 2-flop synchronizer to give lock_s. All decisions use lock_s, which adds 2 cycles of latency.
- PLL_RST:
  - pll_rst=1 for exactly PLL_RST_CYCLES cycles.
  - Then go to WAIT_LOCK and clear the timeout counter.
- WAIT_LOCK:
  - pll_rst=0.
  - lock_s=1 -> STABLE, stable counter cleared.
  - Timeout counter reaching LOCK_TIMEOUT-1 -> retry.
- STABLE:
  - lock_s=0 at any cycle -> retry; no timeout reset.
  - STABLE_CYCLES consecutive lock_s=1 cycles -> RUN.
- Retry: if retry_cnt < MAX_RETRIES-1, increment retry_cnt and go to PLL_RST. Otherwise go to FAULT.
- RUN:
  - video_rst_n=1 and mode_ready=1, both registered, from the first RUN cycle.
  - retry_cnt is held.
  - lock_s=0 -> lock_loss_cnt+1 (saturates at 2^CNT_W-1), retry_cnt cleared, go to PLL_RST with the same mode.
- FAULT: terminal until mode_req or rst_n. pll_rst is held at 1 and video_rst_n at 0.
- video_rst_n is 0 in every state except RUN. It drops in the same cycle the state leaves RUN.
- mode_req in RUN or FAULT:
  - pll_mode <= mode_sel and retry_cnt <= 0; go to PLL_RST next cycle.
  - A request for the mode already running still re-sequences.
- mode_req while busy:
  - mode_sel is latched into a one-deep pending slot; a newer request overwrites it.
  - The current sequence aborts at once and goes to PLL_RST with the pending mode. The pulse counter restarts and retry_cnt is cleared.
- mode_req with mode_sel >= NUM_MODES is ignored; the pending slot and state are unchanged.
- Simultaneous events:
  - mode_req wins over a timeout, a lock drop or stable completion in the same cycle.
  - A lock drop in RUN and mode_req in the same cycle -> request path; lock_loss_cnt still increments.
- Asynchronous rst_n assertion mid-sequence returns all outputs to reset values immediately. The pending request is discarded.

Decomposition:
- Package video_pll_pkg holds:
  - The state enum: PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT.
  - Default timing constants.
  - A per-mode pixel-frequency constant table (25, 40, 65, 75 MHz) used by the PLL configuration mux.
- One sub-module: sync_2ff, a generic 2-flop synchronizer with reset value 0, reused by other CDC points in the HDMI path.

Test Plan:
Sim parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=10, MAX_RETRIES=3.
- Power-up: release rst_n, raise lock 20 cycles after pll_rst falls -> pll_rst high exactly 4 cycles, mode_ready and video_rst_n rise at cycle 20+2+10 after pll_rst falls, pll_mode=0.
- Timeout/fault: lock held 0 -> three 4-cycle pll_rst pulses each followed by 100 cycles of waiting, retry_cnt 0,1,2, then fault=1 with pll_rst held at 1; mode_req with mode_sel=1 -> busy, pll_mode=1, retry_cnt=0.
- Glitch in STABLE: lock drops for 1 cycle at stable count 7 -> retry, retry_cnt=1, no mode_ready; clean second lock -> RUN.
- Lock loss in RUN: drop lock for 3 cycles -> video_rst_n=0 in the same cycle as the state change, lock_loss_cnt=1, pll_mode unchanged, RUN re-entered.
- Request during busy: mode_req mode_sel=2 in WAIT_LOCK, then mode_sel=3 two cycles later -> sequence restarts each time, final pll_mode=3; mode_sel=5 with NUM_MODES=4 -> ignored.
- Async reset mid-STABLE: rst_n low for 1 ns off-edge -> pll_rst=1, video_rst_n=0, counters 0 with no clock edge required.

Source files
------------

// File: rtl/video_pll_pkg.sv
// Shared constants for the video PLL path: FSM state codes, default
// sequencing times and the per-mode pixel-clock frequency table.
package video_pll_pkg;

  // Default timing at the 25 MHz board clock.
  localparam int DEF_NUM_MODES      = 4;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 250000;   // 10 ms
  localparam int DEF_STABLE_CYCLES  = 2500;     // 100 us
  localparam int DEF_MAX_RETRIES    = 3;
  localparam int DEF_CNT_W          = 8;

  // Sequencer states, kept as plain constants so legacy tools and
  // netlists see a stable encoding.
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] PLL_RST   = 3'd0;
  localparam logic [STATE_W-1:0] WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] STABLE    = 3'd2;
  localparam logic [STATE_W-1:0] RUN       = 3'd3;
  localparam logic [STATE_W-1:0] FAULT     = 3'd4;

  // Pixel frequency in MHz for each mode index, consumed by the PLL
  // configuration mux (640x480, 800x600, 1024x768, 1280x720-ish).
  localparam int unsigned MODE_FREQ_MHZ [4] = '{25, 40, 65, 75};

  // Frequency lookup with a safe fallback for out-of-table indices.
  function automatic int unsigned mode_freq_mhz(input int unsigned idx);
    if (idx < 4) return MODE_FREQ_MHZ[idx];
    return MODE_FREQ_MHZ[0];
  endfunction

  // Largest of three timing constants; sizes the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, reset to 0, for single-bit or
// quasi-static multi-bit CDC points in the HDMI path.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  // NOTE: clocked state uses non-blocking assignments so both flops sample
  // their inputs before either updates; blocking here would collapse the
  // chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/video_pll_sequencer.sv
// Run-time mode switch controller for the HDMI/VGA PLL: pulses the PLL
// reset, qualifies lock with a timeout and a stability window, retries,
// and keeps the pixel pipeline in reset until the clocks are trustworthy.
module video_pll_sequencer
  import video_pll_pkg::*;
#(
  parameter int NUM_MODES      = DEF_NUM_MODES,
  parameter int MODE_W         = $clog2(NUM_MODES),
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic              clk_25mhz,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode_sel,
  input  logic              mode_req,
  input  logic              pll_locked_async,
  output logic              pll_rst,
  output logic [MODE_W-1:0] pll_mode,
  output logic              video_rst_n,
  output logic              mode_ready,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        retry_cnt,
  output logic [CNT_W-1:0]  lock_loss_cnt
);

  // One timer serves the reset pulse, the lock timeout and the stability
  // window, since only one of them is ever running.
  localparam int TMR_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRIES - 1);

  logic               lock_s;
  logic [STATE_W-1:0] state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [1:0]         retry_d;
  logic [MODE_W-1:0]  mode_d;
  logic               loss_inc;
  logic               attempt_failed;
  logic               req_ok;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk_25mhz),
    .rst_n (rst_n),
    .d     (pll_locked_async),
    .q     (lock_s)
  );

  // Requests naming a mode outside the table are dropped entirely.
  assign req_ok = mode_req && (32'(mode_sel) < NUM_MODES);

  // Next-state, timer, retry and mode selection for the sequencer.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    tmr_d          = tmr_q;
    retry_d        = retry_cnt;
    mode_d         = pll_mode;
    loss_inc       = 1'b0;
    attempt_failed = 1'b0;

    case (state_q)
      PLL_RST: begin
        if (tmr_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          tmr_d   = '0;
        end else if (tmr_q == TIMEOUT_LAST) begin
          attempt_failed = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      STABLE: begin
        if (!lock_s) begin
          attempt_failed = 1'b1;
        end else if (tmr_q == STABLE_LAST) begin
          state_d = RUN;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      RUN: begin
        // A lock drop in service restarts the same mode with a fresh
        // retry budget.
        if (!lock_s) begin
          loss_inc = 1'b1;
          retry_d  = '0;
          state_d  = PLL_RST;
          tmr_d    = '0;
        end
      end

      FAULT: begin
        state_d = FAULT;
      end

      default: begin
        state_d = PLL_RST;
        tmr_d   = '0;
      end
    endcase

    // A failed attempt either re-pulses the PLL or gives up.
    if (attempt_failed) begin
      tmr_d = '0;
      if (retry_cnt < RETRY_LAST) begin
        retry_d = retry_cnt + 2'd1;
        state_d = PLL_RST;
      end else begin
        state_d = FAULT;
      end
    end

    // A valid request overrides every other event this cycle and aborts
    // whatever is in flight. pll_mode doubles as the one-deep pending
    // slot: the abort is immediate, so the latest request is always the
    // mode being sequenced.
    if (req_ok) begin
      mode_d  = mode_sel;
      retry_d = '0;
      state_d = PLL_RST;
      tmr_d   = '0;
    end
  end

  // Sequencer state, phase timer, retry count, mode and lock-loss count.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PLL_RST;
      tmr_q         <= '0;
      retry_cnt     <= '0;
      pll_mode      <= '0;
      lock_loss_cnt <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      retry_cnt <= retry_d;
      pll_mode  <= mode_d;
      if (loss_inc && (lock_loss_cnt != {CNT_W{1'b1}})) begin
        lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
      end
    end
  end

  // Status outputs registered from the next state, so they change on the
  // same edge as the state and never glitch on a state decode.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst     <= 1'b1;
      video_rst_n <= 1'b0;
      mode_ready  <= 1'b0;
      busy        <= 1'b1;
      fault       <= 1'b0;
    end else begin
      pll_rst     <= (state_d == PLL_RST) || (state_d == FAULT);
      video_rst_n <= (state_d == RUN);
      mode_ready  <= (state_d == RUN);
      busy        <= (state_d == PLL_RST) || (state_d == WAIT_LOCK) ||
                     (state_d == STABLE);
      fault       <= (state_d == FAULT);
    end
  end

endmodule

// File: tb/tb_video_pll_sequencer.sv
// Scoreboard bench for video_pll_sequencer. A behavioural model predicts
// every change of the output bundle together with the cycle it appears in;
// a monitor compares each observed change against the queue.
module tb_video_pll_sequencer;

  localparam int NUM_MODES      = 4;
  localparam int MODE_W         = 3;   // wide enough to express mode 5
  localparam int PLL_RST_CYCLES = 4;
  localparam int LOCK_TIMEOUT   = 100;
  localparam int STABLE_CYCLES  = 10;
  localparam int MAX_RETRIES    = 3;
  localparam int CNT_W          = 8;

  logic              clk_25mhz = 1'b0;
  logic              rst_n = 1'b1;
  logic [MODE_W-1:0] mode_sel = '0;
  logic              mode_req = 1'b0;
  logic              pll_locked_async = 1'b0;
  logic              pll_rst;
  logic [MODE_W-1:0] pll_mode;
  logic              video_rst_n;
  logic              mode_ready;
  logic              busy;
  logic              fault;
  logic [1:0]        retry_cnt;
  logic [CNT_W-1:0]  lock_loss_cnt;

  video_pll_sequencer #(
    .NUM_MODES      (NUM_MODES),
    .MODE_W         (MODE_W),
    .PLL_RST_CYCLES (PLL_RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk_25mhz        (clk_25mhz),
    .rst_n            (rst_n),
    .mode_sel         (mode_sel),
    .mode_req         (mode_req),
    .pll_locked_async (pll_locked_async),
    .pll_rst          (pll_rst),
    .pll_mode         (pll_mode),
    .video_rst_n      (video_rst_n),
    .mode_ready       (mode_ready),
    .busy             (busy),
    .fault            (fault),
    .retry_cnt        (retry_cnt),
    .lock_loss_cnt    (lock_loss_cnt)
  );

  always #5 clk_25mhz = ~clk_25mhz;

  int cyc = 0;
  always @(posedge clk_25mhz) cyc++;

  typedef struct packed {
    logic              pll_rst;
    logic              video_rst_n;
    logic              mode_ready;
    logic              busy;
    logic              fault;
    logic [1:0]        retry;
    logic [CNT_W-1:0]  loss;
    logic [MODE_W-1:0] mode;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t obs;
  } exp_t;

  typedef enum int {P_RESET, P_WAIT, P_QUAL, P_LIVE, P_DEAD} phase_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   rel_cyc = -1;
  int   fall_cyc = -1;
  int   ready_cyc = -1;

  // Reference model: phase, time spent in phase, attempts, losses, mode,
  // and the last two raw lock samples (synchronizer latency).
  phase_t ph = P_RESET;
  int     age = 0;
  int     tries = 0;
  int     losses = 0;
  int     m_mode = 0;
  bit     h1 = 1'b0;
  bit     h2 = 1'b0;
  obs_t   m_prev;

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.pll_rst = 1'b1;
    o.busy    = 1'b1;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.pll_rst     = pll_rst;
    o.video_rst_n = video_rst_n;
    o.mode_ready  = mode_ready;
    o.busy        = busy;
    o.fault       = fault;
    o.retry       = retry_cnt;
    o.loss        = lock_loss_cnt;
    o.mode        = pll_mode;
    return o;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.pll_rst     = (ph == P_RESET) || (ph == P_DEAD);
    o.video_rst_n = (ph == P_LIVE);
    o.mode_ready  = (ph == P_LIVE);
    o.busy        = (ph == P_RESET) || (ph == P_WAIT) || (ph == P_QUAL);
    o.fault       = (ph == P_DEAD);
    o.retry       = 2'(tries);
    o.loss        = CNT_W'(losses);
    o.mode        = MODE_W'(m_mode);
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_push(input int stamp);
    obs_t o;
    o = model_obs();
    if (o != m_prev) begin
      sb.push_back('{stamp, o});
      m_prev = o;
    end
  endtask

  task automatic model_reset();
    ph = P_RESET; age = 0; tries = 0; losses = 0; m_mode = 0;
    h1 = 1'b0; h2 = 1'b0;
    model_push(cyc);
  endtask

  task automatic model_fail();
    if (tries < MAX_RETRIES - 1) begin
      tries++;
      ph = P_RESET;
    end else begin
      ph = P_DEAD;
    end
    age = 0;
  endtask

  // One clock edge of the model, given the inputs presented before it.
  task automatic model_step(input bit raw, input bit req, input int sel);
    bit ls;
    ls = h2;
    h2 = h1;
    h1 = raw;
    case (ph)
      P_RESET: begin
        age++;
        if (age == PLL_RST_CYCLES) begin ph = P_WAIT; age = 0; end
      end
      P_WAIT: begin
        if (ls) begin
          ph = P_QUAL; age = 0;
        end else begin
          age++;
          if (age == LOCK_TIMEOUT) model_fail();
        end
      end
      P_QUAL: begin
        if (!ls) begin
          model_fail();
        end else begin
          age++;
          if (age == STABLE_CYCLES) begin ph = P_LIVE; age = 0; end
        end
      end
      P_LIVE: begin
        if (!ls) begin
          if (losses < (2 ** CNT_W) - 1) losses++;
          tries = 0; ph = P_RESET; age = 0;
        end
      end
      default: ;
    endcase
    if (req && sel < NUM_MODES) begin
      m_mode = sel; tries = 0; ph = P_RESET; age = 0;
    end
    model_push(cyc + 1);
  endtask

  // Present inputs for the next edge, advance the model, then move to
  // 2 ns after that edge.
  task automatic drive(input bit raw, input bit req = 1'b0, input int sel = 0);
    pll_locked_async = raw;
    mode_req         = req;
    mode_sel         = MODE_W'(sel);
    model_step(raw, req, sel);
    @(posedge clk_25mhz);
    #2;
  endtask

  task automatic run(input int n, input bit raw);
    repeat (n) drive(raw);
  endtask

  // Monitor: every change in the DUT output bundle must match the next
  // predicted change, both in value and in cycle.
  initial begin
    obs_t prev, cur;
    exp_t e;
    prev = reset_obs();
    wait (mon_en);
    forever begin
      @(negedge clk_25mhz);
      cur = dut_obs();
      if (cur != prev) begin
        if (prev.pll_rst && !cur.pll_rst && fall_cyc < 0) fall_cyc = cyc;
        if (!prev.mode_ready && cur.mode_ready && ready_cyc < 0) ready_cyc = cyc;
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("obs_bundle", 32'(cur), 32'(e.obs));
          check("obs_cycle", 32'(cyc), 32'(e.cyc));
        end
        prev = cur;
      end
    end
  end

  initial begin
    int  hold;
    bit  raw;
    m_prev = reset_obs();

    // Reset state, asserted off-edge before the first clock.
    #3 rst_n = 1'b0;
    #1;
    check("reset_obs", 32'(dut_obs()), 32'(reset_obs()));
    repeat (3) @(posedge clk_25mhz);
    #2;
    rst_n   = 1'b1;
    rel_cyc = cyc;
    mon_en  = 1'b1;

    // Power-up: mode 0; raw lock first sampled on the 20th edge after
    // pll_rst falls.
    run(PLL_RST_CYCLES, 1'b0);
    run(19, 1'b0);
    run(40, 1'b1);
    check("pwr_pulse_width", 32'(fall_cyc - rel_cyc), 32'(PLL_RST_CYCLES));
    check("pwr_ready_delay", 32'(ready_cyc - fall_cyc), 32'(20 + 2 + STABLE_CYCLES));
    check("pwr_mode", 32'(pll_mode), 32'd0);
    check("pwr_video_rst_n", 32'(video_rst_n), 32'd1);

    // Lock loss in RUN: 3-cycle drop, then recovery of the same mode.
    run(3, 1'b0);
    run(60, 1'b1);
    check("loss_cnt", 32'(lock_loss_cnt), 32'd1);
    check("loss_mode", 32'(pll_mode), 32'd0);
    check("loss_rerun", 32'(mode_ready), 32'd1);

    // Timeout path: lock never returns, three attempts, then fault.
    run(3 * (PLL_RST_CYCLES + LOCK_TIMEOUT) + 20, 1'b0);
    check("flt_fault", 32'(fault), 32'd1);
    check("flt_pll_rst", 32'(pll_rst), 32'd1);
    check("flt_video_rst_n", 32'(video_rst_n), 32'd0);
    check("flt_retry", 32'(retry_cnt), 32'd2);
    drive(1'b0, 1'b1, 1);
    check("flt_req_busy", 32'(busy), 32'd1);
    check("flt_req_mode", 32'(pll_mode), 32'd1);
    check("flt_req_retry", 32'(retry_cnt), 32'd0);

    // One-cycle glitch landing at stable count 7, then a clean lock.
    for (int i = 0; i < 200 && !(ph == P_QUAL && age == 5); i++) drive(1'b1);
    drive(1'b0);
    run(80, 1'b1);
    check("glitch_retry", 32'(retry_cnt), 32'd1);
    check("glitch_ready", 32'(mode_ready), 32'd1);

    // Requests while busy: 2 in WAIT_LOCK, 3 two cycles later, 5 ignored.
    drive(1'b0, 1'b1, 0);
    for (int i = 0; i < 200 && !(ph == P_WAIT && age == 10); i++) drive(1'b0);
    drive(1'b0, 1'b1, 2);
    drive(1'b0);
    drive(1'b0, 1'b1, 3);
    run(2, 1'b0);
    drive(1'b0, 1'b1, 5);
    run(60, 1'b1);
    check("busy_req_mode", 32'(pll_mode), 32'd3);
    check("busy_req_ready", 32'(mode_ready), 32'd1);

    // Async reset pulse in the middle of STABLE.
    drive(1'b1, 1'b1, 1);
    for (int i = 0; i < 200 && !(ph == P_QUAL && age == 4); i++) drive(1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_pll_rst", 32'(pll_rst), 32'd1);
    check("arst_video_rst_n", 32'(video_rst_n), 32'd0);
    check("arst_retry", 32'(retry_cnt), 32'd0);
    check("arst_loss", 32'(lock_loss_cnt), 32'd0);
    check("arst_mode", 32'(pll_mode), 32'd0);
    check("arst_busy", 32'(busy), 32'd1);
    rst_n = 1'b1;
    model_reset();
    run(60, 1'b1);
    check("arst_rerun_ready", 32'(mode_ready), 32'd1);

    // Randomised lock waveform and sparse requests, including illegal modes.
    hold = 0;
    raw  = 1'b1;
    repeat (3000) begin
      if (hold == 0) begin
        raw  = ($urandom_range(0, 3) != 0);
        hold = raw ? int'($urandom_range(20, 400))
                   : (($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 6))
                                                  : int'($urandom_range(1, 150)));
      end
      hold--;
      drive(raw, ($urandom_range(0, 79) == 0), int'($urandom_range(0, 7)));
    end
    run(5, 1'b1);

    @(negedge clk_25mhz);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_obs", 32'(dut_obs()), 32'(m_prev));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
